// File: rtl/lmc_pkg.sv
// Shared opcode encodings and FSM state type for the LMC R4 core.
package lmc_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HLT = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB = 3'b010;
    localparam logic [OP_W-1:0] OP_STA = 3'b011;
    localparam logic [OP_W-1:0] OP_LDA = 3'b100;
    localparam logic [OP_W-1:0] OP_BRA = 3'b101;
    localparam logic [OP_W-1:0] OP_BRZ = 3'b110;
    localparam logic [OP_W-1:0] OP_IO  = 3'b111;

    typedef enum logic [1:0] {
        HALT,
        FETCH,
        EXEC
    } state_t;

endpackage

// File: rtl/lmc_ram.sv
// Program/data RAM: one synchronous write port, two combinational read ports.
module lmc_ram #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata     = mem[raddr];
    assign dbg_rdata = mem[dbg_addr];

endmodule

// File: rtl/lmc_r4_core.sv
// Self-sequencing Little Man Computer core: manual front panel while
// halted, two-cycle fetch/execute of eight opcodes while running.
module lmc_r4_core
    import lmc_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  timer555,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  prog_we,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] acc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  carry,
    output logic                  halted
);

    if (DATA_WIDTH < OP_W + ADDR_WIDTH) begin : g_width_chk
        $error("lmc_r4_core: DATA_WIDTH too small for opcode plus address");
    end

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;

    state_t                  state, state_nxt;
    logic                    run_q;
    logic                    run_edge;
    logic [OP_W-1:0]         ir_op;
    logic [ADDR_WIDTH-1:0]   ir_addr;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH:0]     sum;
    logic [DATA_WIDTH:0]     diff;

    assign run_edge = run & ~run_q;
    assign halted   = (state == HALT);
    assign rd_addr  = (state == FETCH) ? pc : ir_addr;
    assign sum      = {1'b0, acc} + {1'b0, rd_data};
    assign diff     = {1'b0, acc} - {1'b0, rd_data};

    lmc_ram #(
        .AW(ADDR_WIDTH),
        .DW(DATA_WIDTH)
    ) u_ram (
        .clk      (timer555),
        .we       (ram_we & ~reset),
        .waddr    (ram_waddr),
        .wdata    (ram_wdata),
        .raddr    (rd_addr),
        .rdata    (rd_data),
        .dbg_addr (prog_addr),
        .dbg_rdata(mem_rdata)
    );

    always_ff @(posedge timer555 or posedge reset) begin
        if (reset) state <= HALT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            HALT:    if (run_edge) state_nxt = FETCH;
            FETCH:   state_nxt = EXEC;
            EXEC:    state_nxt = (ir_op == OP_HLT) ? HALT : FETCH;
            default: state_nxt = HALT;
        endcase
    end

    // Front-panel writes only while halted; STA only in its execute cycle.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = prog_addr;
        ram_wdata = prog_data;
        if (state == HALT && prog_we) begin
            ram_we = 1'b1;
        end else if (state == EXEC && ir_op == OP_STA) begin
            ram_we    = 1'b1;
            ram_waddr = ir_addr;
            ram_wdata = acc;
        end
    end

    always_ff @(posedge timer555 or posedge reset) begin
        if (reset) begin
            run_q     <= 1'b0;
            acc       <= '0;
            pc        <= '0;
            ir_op     <= '0;
            ir_addr   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
        end else begin
            run_q     <= run;
            out_valid <= 1'b0;
            unique case (state)
                HALT: begin
                    if (pc_load) pc <= prog_addr;
                end
                FETCH: begin
                    ir_op   <= rd_data[DATA_WIDTH-1 -: OP_W];
                    ir_addr <= rd_data[ADDR_WIDTH-1:0];
                    pc      <= pc + PC_ONE;
                end
                EXEC: begin
                    unique case (ir_op)
                        OP_HLT: ;
                        OP_ADD: {carry, acc} <= sum;
                        OP_SUB: {carry, acc} <= diff;
                        OP_STA: ;
                        OP_LDA: acc <= rd_data;
                        OP_BRA: pc <= ir_addr;
                        OP_BRZ: if (acc == '0) pc <= ir_addr;
                        OP_IO: begin
                            if (ir_addr[0]) begin
                                out_data  <= acc;
                                out_valid <= 1'b1;
                            end else begin
                                acc <= in_data;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lmc_r4_core.sv
// Directed self-checking bench for lmc_r4_core.
module tb_lmc_r4_core;

    logic       timer555 = 1'b0;
    logic       reset;
    logic       run;
    logic       prog_we;
    logic       pc_load;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] in_data;
    logic [7:0] mem_rdata;
    logic [7:0] acc;
    logic [3:0] pc;
    logic [7:0] out_data;
    logic       out_valid;
    logic       carry;
    logic       halted;

    int checks   = 0;
    int failures = 0;
    int cycles;
    int pulses;
    logic [7:0] last_out;

    lmc_r4_core #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(8)
    ) dut (
        .timer555 (timer555),
        .reset    (reset),
        .run      (run),
        .prog_we  (prog_we),
        .pc_load  (pc_load),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .in_data  (in_data),
        .mem_rdata(mem_rdata),
        .acc      (acc),
        .pc       (pc),
        .out_data (out_data),
        .out_valid(out_valid),
        .carry    (carry),
        .halted   (halted)
    );

    always #5 timer555 = ~timer555;

    task automatic cyc();
        @(posedge timer555);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        prog_addr = a;
        prog_data = d;
        prog_we   = 1'b1;
        cyc();
        prog_we   = 1'b0;
    endtask

    // Load PC with start in the same cycle as the run edge, then wait for HALT.
    task automatic run_prog(input logic [3:0] start, input bit keep_run, input int max);
        cycles    = 0;
        pulses    = 0;
        last_out  = 8'h00;
        prog_addr = start;
        pc_load   = 1'b1;
        run       = 1'b1;
        cyc();
        pc_load = 1'b0;
        if (!keep_run) run = 1'b0;
        while (halted !== 1'b1 && cycles < max) begin
            cyc();
            cycles++;
            if (out_valid === 1'b1) begin
                pulses++;
                last_out = out_data;
            end
        end
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL run_timeout start=%0h halted=%b want 1", start, halted);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 0; prog_we = 0; pc_load = 0;
        prog_addr = '0; prog_data = '0; in_data = '0;
        cyc();
        cyc();
        checks++;
        if ({acc, pc, out_data, out_valid, carry, halted} !== {8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset acc=%h pc=%h out=%h ov=%b c=%b h=%b want 0 0 0 0 0 1",
                     acc, pc, out_data, out_valid, carry, halted);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        wr(4'h0, 8'h88); wr(4'h1, 8'h29); wr(4'h2, 8'hE1); wr(4'h3, 8'h00);
        wr(4'h8, 8'h05); wr(4'h9, 8'h07);
        run_prog(4'h0, 1'b0, 60);
        checks++;
        if (last_out !== 8'h0C || out_data !== 8'h0C) begin
            failures++; $display("FAIL basic_out got %h want 0c", out_data);
        end
        checks++;
        if (pulses !== 1) begin
            failures++; $display("FAIL basic_pulses got %0d want 1", pulses);
        end
        checks++;
        if (cycles !== 8) begin
            failures++; $display("FAIL basic_cycles got %0d want 8", cycles);
        end
        checks++;
        if (pc !== 4'h4 || acc !== 8'h0C || carry !== 1'b0) begin
            failures++;
            $display("FAIL basic_state pc=%h acc=%h c=%b want 4 0c 0", pc, acc, carry);
        end
    endtask

    task automatic test_carry();
        wr(4'h8, 8'hFF); wr(4'h9, 8'h02);
        run_prog(4'h0, 1'b0, 60);
        checks++;
        if (acc !== 8'h01 || carry !== 1'b1 || out_data !== 8'h01) begin
            failures++;
            $display("FAIL add_carry acc=%h c=%b out=%h want 01 1 01", acc, carry, out_data);
        end
        wr(4'h8, 8'h01);
        wr(4'hA, 8'h88); wr(4'hB, 8'h49); wr(4'hC, 8'h00);
        run_prog(4'hA, 1'b0, 60);
        checks++;
        if (acc !== 8'hFF || carry !== 1'b1 || pc !== 4'hD) begin
            failures++;
            $display("FAIL sub_borrow acc=%h c=%b pc=%h want ff 1 d", acc, carry, pc);
        end
    endtask

    task automatic test_loop();
        wr(4'h0, 8'h49); wr(4'h1, 8'hC3); wr(4'h2, 8'hA0); wr(4'h3, 8'h00);
        wr(4'h4, 8'hE0); wr(4'h5, 8'hA0); wr(4'h9, 8'h01);
        in_data = 8'h03;
        run_prog(4'h4, 1'b0, 200);
        checks++;
        if (acc !== 8'h00 || pc !== 4'h4 || carry !== 1'b0) begin
            failures++;
            $display("FAIL loop_state acc=%h pc=%h c=%b want 00 4 0", acc, pc, carry);
        end
        checks++;
        if (cycles !== 22) begin
            failures++; $display("FAIL loop_cycles got %0d want 22", cycles);
        end
    endtask

    task automatic test_pc_load_run();
        wr(4'h0, 8'h00); wr(4'h5, 8'h88); wr(4'h6, 8'h00); wr(4'h8, 8'h33);
        run_prog(4'h5, 1'b0, 60);
        checks++;
        if (acc !== 8'h33 || pc !== 4'h7 || cycles !== 4) begin
            failures++;
            $display("FAIL pcload_run acc=%h pc=%h cyc=%0d want 33 7 4", acc, pc, cycles);
        end
    endtask

    task automatic test_ignore_running();
        wr(4'h0, 8'h88); wr(4'h1, 8'h00); wr(4'h8, 8'h44);
        prog_addr = 4'h0; pc_load = 1'b1; run = 1'b1;
        cyc();
        run = 1'b0;
        prog_addr = 4'h8; prog_data = 8'h99; prog_we = 1'b1; pc_load = 1'b1;
        cyc(); cyc(); cyc();
        prog_we = 1'b0; pc_load = 1'b0;
        cyc();
        checks++;
        if (halted !== 1'b1 || pc !== 4'h2 || acc !== 8'h44) begin
            failures++;
            $display("FAIL ignore_state h=%b pc=%h acc=%h want 1 2 44", halted, pc, acc);
        end
        checks++;
        if (mem_rdata !== 8'h44) begin
            failures++; $display("FAIL ignore_we ram8=%h want 44", mem_rdata);
        end
    endtask

    task automatic test_wrap();
        wr(4'hF, 8'h88); wr(4'h0, 8'h00); wr(4'h8, 8'h21);
        run_prog(4'hF, 1'b0, 60);
        checks++;
        if (acc !== 8'h21 || pc !== 4'h1 || cycles !== 4) begin
            failures++;
            $display("FAIL pc_wrap acc=%h pc=%h cyc=%0d want 21 1 4", acc, pc, cycles);
        end
    endtask

    task automatic test_run_held();
        wr(4'h0, 8'h00); wr(4'h1, 8'h00);
        run_prog(4'h0, 1'b1, 60);
        checks++;
        if (cycles !== 2) begin
            failures++; $display("FAIL hlt_cycles got %0d want 2", cycles);
        end
        for (int i = 0; i < 4; i++) cyc();
        checks++;
        if (halted !== 1'b1 || pc !== 4'h1) begin
            failures++;
            $display("FAIL run_held h=%b pc=%h want 1 1", halted, pc);
        end
        run = 1'b0;
        cyc();
        run = 1'b1;
        cyc();
        checks++;
        if (halted !== 1'b0) begin
            failures++; $display("FAIL run_retoggle h=%b want 0", halted);
        end
        run = 1'b0;
        cyc(); cyc();
        checks++;
        if (halted !== 1'b1 || pc !== 4'h2) begin
            failures++;
            $display("FAIL rerun_halt h=%b pc=%h want 1 2", halted, pc);
        end
    endtask

    task automatic test_reset_sta();
        wr(4'h0, 8'hE0); wr(4'h1, 8'h67); wr(4'h2, 8'h00); wr(4'h7, 8'h5A);
        in_data = 8'h77;
        prog_addr = 4'h0; pc_load = 1'b1; run = 1'b1;
        cyc();
        pc_load = 1'b0; run = 1'b0;
        cyc(); cyc(); cyc();
        checks++;
        if (acc !== 8'h77 || halted !== 1'b0 || pc !== 4'h2) begin
            failures++;
            $display("FAIL pre_abort acc=%h h=%b pc=%h want 77 0 2", acc, halted, pc);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b1 || acc !== 8'h00 || pc !== 4'h0) begin
            failures++;
            $display("FAIL abort_state h=%b acc=%h pc=%h want 1 00 0", halted, acc, pc);
        end
        cyc();
        reset = 1'b0;
        prog_addr = 4'h7;
        #1;
        checks++;
        if (mem_rdata !== 8'h5A) begin
            failures++; $display("FAIL abort_sta ram7=%h want 5a", mem_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_loop();
        test_pc_load_run();
        test_ignore_running();
        test_wrap();
        test_run_held();
        test_reset_sta();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
